// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer queue: default byte width and FSM states.
package spi_pkg;

  localparam int unsigned SpiDw = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitDone = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous FIFO with a separate occupancy register. Pushes are refused when
// full (even if a pop happens in the same cycle); pops are ignored when empty.
// The head entry is read straight out of the storage registers.
module spi_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [DW-1:0]              wdata_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Status and accepted handshakes derived from the occupancy register.
  always_comb begin
    full_o  = (count_q == LW'(DEPTH));
    empty_o = (count_q == '0);
    level_o = count_q;
    rdata_o = mem_q[rptr_q];
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
  end

  // Next-state for storage, pointers (wrap naturally) and count.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = wptr_q + AW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + LW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - LW'(1);
    end
  end

  // State registers; storage is cleared so the head reads 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spi_xfer_queue.sv
// Byte-queueing front end for the SPI master: TX FIFO feeds start/tx_data one
// transfer at a time, each done pulse pushes rx_data into the RX FIFO.
// Optional watchdog on WAIT_DONE enabled by the macro SPI_XFER_TIMEOUT_EN.
module spi_xfer_queue
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DW          = SpiDw,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  input  logic [DW-1:0]              s_data,
  output logic                       s_ready,
  output logic                       m_valid,
  output logic [DW-1:0]              m_data,
  input  logic                       m_ready,
  output logic                       spi_start,
  output logic [DW-1:0]              spi_tx_data,
  input  logic                       spi_busy,
  input  logic                       spi_done,
  input  logic [DW-1:0]              spi_rx_data,
  output logic [$clog2(DEPTH+1)-1:0] tx_level,
  output logic [$clog2(DEPTH+1)-1:0] rx_level,
  output logic                       idle,
  output logic                       err
);

  spi_state_e    state_q, state_d;
  logic          spi_start_q, spi_start_d;
  logic [DW-1:0] spi_tx_data_q, spi_tx_data_d;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [DW-1:0] tx_head;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic          timeout;

  // Busy is informational only; sequencing relies solely on the done pulse.
  logic unused_busy;
  assign unused_busy = spi_busy;

  // Host-side handshakes.
  always_comb begin
    s_ready = !tx_full;
    tx_push = s_valid && s_ready;
    m_valid = !rx_empty;
    rx_pop  = m_valid && m_ready;
  end

  spi_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (tx_push),
    .wdata_i (s_data),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level)
  );

  spi_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_rx_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (rx_push),
    .wdata_i (spi_rx_data),
    .pop_i   (rx_pop),
    .rdata_o (m_data),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level)
  );

`ifdef SPI_XFER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC+1);

  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic          err_q, err_d;

  // Watchdog counts WAIT_DONE cycles and restarts on every entry.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == StWaitDone) begin
      wd_cnt_d = wd_cnt_q + TW'(1);
    end
    timeout = (state_q == StWaitDone) && !spi_done && (wd_cnt_q == TW'(TIMEOUT_CYC - 1));
    err_d   = err_q || timeout;
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  // Without the watchdog the limit is irrelevant; keep it referenced.
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign timeout            = 1'b0;
  assign err                = 1'b0;
`endif

  // FSM state and registered SPI-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      spi_start_q   <= 1'b0;
      spi_tx_data_q <= '0;
    end else begin
      state_q       <= state_d;
      spi_start_q   <= spi_start_d;
      spi_tx_data_q <= spi_tx_data_d;
    end
  end

  // Next state: one transfer outstanding at most, so a free RX slot at issue
  // time is guaranteed to still be free when done arrives.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!tx_empty && !rx_full) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (spi_done || timeout) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: start/tx_data are loaded on the IDLE->ISSUE edge so they are
  // registered and coincide with the ISSUE cycle; tx_data then holds.
  always_comb begin
    spi_start_d   = (state_q == StIdle) && (state_d == StIssue);
    spi_tx_data_d = spi_start_d ? tx_head : spi_tx_data_q;
    tx_pop        = (state_q == StIssue);
    rx_push       = (state_q == StWaitDone) && spi_done;
    spi_start     = spi_start_q;
    spi_tx_data   = spi_tx_data_q;
    idle          = (state_q == StIdle) && tx_empty;
  end

endmodule
